// File: rtl/morse_pkg.sv
// Shared widths, receiver FSM states and Morse gap / ASCII constants.
package morse_pkg;

    localparam int PAT_W = 24;

    localparam int LETTER_GAP = 3;
    localparam int WORD_GAP   = 7;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NONE  = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT,
        CAPTURE,
        GAP
    } rx_state_t;

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timebase: one-cycle tick per unit and the key sample taken at that tick.
// MORSE_GLITCH_FILTER_EN adds a 3-sample majority filter on the key line.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic key_in,
    output logic tick,
    output logic s
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(UNIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = en && (cnt == LAST);

`ifdef MORSE_GLITCH_FILTER_EN
    logic [2:0] hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hist <= '0;
        else
            hist <= {hist[1:0], key_in};
    end

    // Majority of the three most recent samples; a lone glitch cannot win.
    assign s = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign s = key_in;
`endif

endmodule

// File: rtl/morse_rx_ctrl.sv
// Morse receive sequencer: builds element patterns, drives the dc decoder and buffers ASCII out.
// Optional key glitch filter lives in morse_unit_timer under MORSE_GLITCH_FILTER_EN.
module morse_rx_ctrl
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 1000,
    parameter int PAT_W       = morse_pkg::PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             key_in,
    output logic [PAT_W-1:0] dc_x,
    input  logic [7:0]       dc_y,
    output logic [7:0]       char_out,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             overrun,
    output logic             unknown
);

    logic tick;
    logic s;

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .key_in (key_in),
        .tick   (tick),
        .s      (s)
    );

    rx_state_t        state, state_nxt;
    logic [PAT_W-1:0] pattern, pattern_nxt, new_pat, dc_x_nxt;
    logic [2:0]       zero_cnt, zero_nxt;
    logic             offer, unknown_set;
    logic [7:0]       offer_char;
    logic [7:0]       char_nxt;
    logic             valid_nxt, overrun_nxt, unknown_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pattern    <= '0;
            zero_cnt   <= '0;
            dc_x       <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            overrun    <= 1'b0;
            unknown    <= 1'b0;
        end else begin
            state      <= state_nxt;
            pattern    <= pattern_nxt;
            zero_cnt   <= zero_nxt;
            dc_x       <= dc_x_nxt;
            char_out   <= char_nxt;
            char_valid <= valid_nxt;
            overrun    <= overrun_nxt;
            unknown    <= unknown_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        zero_nxt    = zero_cnt;
        dc_x_nxt    = dc_x;
        offer       = 1'b0;
        offer_char  = ASCII_SPACE;
        unknown_set = 1'b0;
        new_pat     = {pattern[PAT_W-2:0], s};
        case (state)
            IDLE: begin
                pattern_nxt = '0;
                if (tick && s) begin
                    pattern_nxt = PAT_W'(1);
                    zero_nxt    = '0;
                    state_nxt   = COLLECT;
                end
            end
            COLLECT: if (tick) begin
                if (pattern[PAT_W-1]) begin
                    unknown_set = 1'b1;
                    pattern_nxt = '0;
                    zero_nxt    = '0;
                    state_nxt   = GAP;
                end else begin
                    pattern_nxt = new_pat;
                    zero_nxt    = s ? 3'd0 : zero_cnt + 3'd1;
                    // Third silent unit: drop two of the three trailing zeros.
                    if (!s && zero_cnt == 3'(LETTER_GAP - 1)) begin
                        dc_x_nxt  = new_pat >> 2;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = CAPTURE;
            CAPTURE: begin
                zero_nxt  = 3'(LETTER_GAP);
                state_nxt = GAP;
                if (dc_x == '0) begin
                    // Word-gap lookup: emit one space, then rest in IDLE.
                    offer       = 1'b1;
                    offer_char  = ASCII_SPACE;
                    pattern_nxt = '0;
                    zero_nxt    = '0;
                    state_nxt   = IDLE;
                end else if (dc_y == ASCII_NONE) begin
                    unknown_set = 1'b1;
                end else begin
                    offer      = 1'b1;
                    offer_char = dc_y;
                end
            end
            GAP: if (tick) begin
                if (s) begin
                    pattern_nxt = PAT_W'(1);
                    zero_nxt    = '0;
                    state_nxt   = COLLECT;
                end else begin
                    zero_nxt = zero_cnt + 3'd1;
                    if (zero_cnt == 3'(WORD_GAP - 1)) begin
                        dc_x_nxt  = '0;
                        state_nxt = ISSUE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!en) begin
            state_nxt   = IDLE;
            pattern_nxt = '0;
            zero_nxt    = '0;
            offer       = 1'b0;
            unknown_set = 1'b0;
        end
    end

    // 1-deep holding register; a full register that is not being drained drops the offer.
    always_comb begin
        char_nxt    = char_out;
        valid_nxt   = char_valid;
        overrun_nxt = overrun;
        unknown_nxt = unknown | unknown_set;
        if (offer) begin
            if (!char_valid || char_ready) begin
                char_nxt  = offer_char;
                valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (char_ready) begin
            valid_nxt = 1'b0;
        end
    end

endmodule
